// File: rtl/music_seq_pkg.sv
// rtl/music_seq_pkg.sv - shared types and widths for the note sequencer
// Purpose: note command record, sequencer state encoding and field widths
//   used by the FIFO, the command interface and the sequencer top.
// Ports: none (package).
// Configuration: SEQ_GAP_EN (see music_note_sequencer) uses the GAP state.
package music_seq_pkg;

  localparam int FREQ_W = 16;
  localparam int VOL_W  = 8;
  localparam int DUR_W  = 16;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [VOL_W-1:0]  volume;
    logic [DUR_W-1:0]  dur;
    logic              rest;
  } note_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/music_note_sequencer_if.sv
// rtl/music_note_sequencer_if.sv - note command valid/ready interface
// Purpose: groups the upstream note command handshake and payload.
// Signals: cmd_valid_i, cmd_ready_o, cmd_freq_i[16], cmd_volume_i[8],
//   cmd_dur_i[16], cmd_rest_i. master = note source, slave = sequencer.
interface music_note_sequencer_if;
  import music_seq_pkg::*;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [FREQ_W-1:0] cmd_freq_i;
  logic [VOL_W-1:0]  cmd_volume_i;
  logic [DUR_W-1:0]  cmd_dur_i;
  logic              cmd_rest_i;

  modport master (
    output cmd_valid_i, cmd_freq_i, cmd_volume_i, cmd_dur_i, cmd_rest_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_freq_i, cmd_volume_i, cmd_dur_i, cmd_rest_i,
    output cmd_ready_o
  );

endinterface

// File: rtl/music_seq_fifo.sv
// rtl/music_seq_fifo.sv - command FIFO of note_cmd_t
// Purpose: synchronous FIFO holding queued note commands, no bypass path.
// Ports: clk_i, rst_i (async, active-high), push, pop, flush (clears all,
//   wins over push/pop), wdata, rdata (head entry), full, empty, level.
module music_seq_fifo
  import music_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  note_cmd_t              wdata,
  output note_cmd_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  note_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  // Ready is !full regardless of a same-cycle pop, so a full FIFO never accepts.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/music_note_sequencer.sv
// rtl/music_note_sequencer.sv - plays queued note commands on one synth voice
// Purpose: pops note commands from the FIFO and drives ch_en/ch_freq/ch_volume
//   for dur*TICK_DIV cycles each; back-to-back notes reload without a bubble.
// Ports: clk_i, rst_i (async, active-high), cmd (slave command interface),
//   pause_i (freeze timing, silence), flush_i (drop queue and current note),
//   ch_en_o, ch_freq_o, ch_volume_o (registered synth controls),
//   busy_o (state != IDLE), level_o (FIFO occupancy).
// Configuration: SEQ_GAP_EN adds a GAP_TICKS silent gap after every note.
module music_note_sequencer
  import music_seq_pkg::*;
#(
  parameter int TICK_DIV   = 12500,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_TICKS  = 20
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  music_note_sequencer_if.slave       cmd,
  input  logic                        pause_i,
  input  logic                        flush_i,
  output logic                        ch_en_o,
  output logic [FREQ_W-1:0]           ch_freq_o,
  output logic [VOL_W-1:0]            ch_volume_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  seq_state_e        state, state_n;
  logic [PW-1:0]     presc, presc_n, presc_adv;
  logic [DUR_W-1:0]  tick, tick_n, tick_adv, tick_tgt;
  logic [DUR_W-1:0]  cur_dur, dur_n;
  logic              cur_rest, rest_n;
  logic              en_q, en_n;
  logic [FREQ_W-1:0] freq_q, freq_n;
  logic [VOL_W-1:0]  vol_q, vol_n;
  logic              presc_wrap, slot_end;
  logic              pop, load, head_ok;
  logic              fifo_full, fifo_empty;
  note_cmd_t         wdata, head;

  assign wdata.freq   = cmd.cmd_freq_i;
  assign wdata.volume = cmd.cmd_volume_i;
  assign wdata.dur    = cmd.cmd_dur_i;
  assign wdata.rest   = cmd.cmd_rest_i;

  music_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (cmd.cmd_valid_i),
    .pop   (pop),
    .flush (flush_i),
    .wdata (wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign cmd.cmd_ready_o = !fifo_full;
  assign ch_en_o         = en_q;
  assign ch_freq_o       = freq_q;
  assign ch_volume_o     = vol_q;
  assign busy_o          = (state != IDLE);

  // A zero-duration head is popped but never loaded.
  assign head_ok = !fifo_empty && (head.dur != '0);

`ifdef SEQ_GAP_EN
  assign tick_tgt = (state == GAP) ? DUR_W'(GAP_TICKS) : cur_dur;
`else
  logic [DUR_W-1:0] gap_unused;
  assign gap_unused = DUR_W'(GAP_TICKS);
  assign tick_tgt   = cur_dur;
`endif

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign presc_adv  = presc_wrap ? '0 : presc + PW'(1);
  assign tick_adv   = presc_wrap ? tick + DUR_W'(1) : tick;
  // Final cycle of the current slot: last prescaler count of the last tick.
  assign slot_end   = presc_wrap && (tick == tick_tgt - DUR_W'(1));

  always_comb begin
    state_n = state;
    presc_n = presc;
    tick_n  = tick;
    dur_n   = cur_dur;
    rest_n  = cur_rest;
    freq_n  = freq_q;
    vol_n   = vol_q;
    en_n    = en_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      presc_n = '0;
      tick_n  = '0;
      en_n    = 1'b0;
    end else if (pause_i) begin
      en_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          en_n = 1'b0;
          pop  = !fifo_empty;
          load = head_ok;
        end
        PLAY: begin
          en_n = !cur_rest;
          if (slot_end) begin
`ifdef SEQ_GAP_EN
            state_n = GAP;
            presc_n = '0;
            tick_n  = '0;
            en_n    = 1'b0;
`else
            pop  = !fifo_empty;
            load = head_ok;
            if (!head_ok) begin
              state_n = IDLE;
              en_n    = 1'b0;
            end
`endif
          end else begin
            presc_n = presc_adv;
            tick_n  = tick_adv;
          end
        end
`ifdef SEQ_GAP_EN
        GAP: begin
          en_n = 1'b0;
          if (slot_end) begin
            pop  = !fifo_empty;
            load = head_ok;
            if (!head_ok) state_n = IDLE;
          end else begin
            presc_n = presc_adv;
            tick_n  = tick_adv;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          en_n    = 1'b0;
        end
      endcase
      if (load) begin
        state_n = PLAY;
        presc_n = '0;
        tick_n  = '0;
        dur_n   = head.dur;
        rest_n  = head.rest;
        freq_n  = head.freq;
        vol_n   = head.volume;
        en_n    = !head.rest;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      presc    <= '0;
      tick     <= '0;
      cur_dur  <= '0;
      cur_rest <= 1'b0;
      en_q     <= 1'b0;
      freq_q   <= '0;
      vol_q    <= '0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      tick     <= tick_n;
      cur_dur  <= dur_n;
      cur_rest <= rest_n;
      en_q     <= en_n;
      freq_q   <= freq_n;
      vol_q    <= vol_n;
    end
  end

endmodule

// File: tb/tb_music_note_sequencer.sv
// tb/tb_music_note_sequencer.sv - directed self-checking bench for music_note_sequencer
module tb_music_note_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_TICKS  = 2;
`ifdef SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        pause = 1'b0;
  logic        flush = 1'b0;
  logic        ch_en;
  logic [15:0] ch_freq;
  logic [7:0]  ch_vol;
  logic        busy;
  logic [2:0]  level;
  int          n_cmp = 0;
  int          n_bad = 0;

  music_note_sequencer_if sif ();

  music_note_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd         (sif),
    .pause_i     (pause),
    .flush_i     (flush),
    .ch_en_o     (ch_en),
    .ch_freq_o   (ch_freq),
    .ch_volume_o (ch_vol),
    .busy_o      (busy),
    .level_o     (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] f, input logic [7:0] v, input logic [15:0] d, input logic r);
    sif.cmd_valid_i  = 1'b1;
    sif.cmd_freq_i   = f;
    sif.cmd_volume_i = v;
    sif.cmd_dur_i    = d;
    sif.cmd_rest_i   = r;
    step();
    sif.cmd_valid_i  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && busy; i++) step();
    chk(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sif.cmd_valid_i  = 1'b0;
    sif.cmd_freq_i   = '0;
    sif.cmd_volume_i = '0;
    sif.cmd_dur_i    = '0;
    sif.cmd_rest_i   = 1'b0;
    step();
    step();
    chk("rst0_en", ch_en, 0);
    chk("rst0_ready", sif.cmd_ready_o, 1);
    chk("rst0_level", level, 0);
    rst = 1'b0;
    step();

    // Reset asserted in the middle of a note with one entry queued.
    push(16'd4208, 8'hff, 16'd3, 1'b0);
    push(16'd1000, 8'h10, 16'd1, 1'b0);
    step();
    step();
    chk("rst_pre_en", ch_en, 1);
    chk("rst_pre_level", level, 1);
    rst = 1'b1;
    #2;
    chk("rst_en", ch_en, 0);
    chk("rst_freq", ch_freq, 0);
    chk("rst_vol", ch_vol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sif.cmd_ready_o, 1);
    chk("rst_level", level, 0);
    step();
    rst = 1'b0;
    step();

    // Single note: 3 ticks * 4 cycles = 12 cycles of ch_en.
    push(16'd4208, 8'hff, 16'd3, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("single_en_k%0d", k), ch_en, (k <= 12) ? 1 : 0);
      if (k == 1) begin
        chk("single_freq", ch_freq, 4208);
        chk("single_vol", ch_vol, 8'hff);
        chk("single_busy", busy, 1);
      end
    end
    chk("single_busy_end", busy, GAP_ON ? 1 : 0);
    chk("single_freq_hold", ch_freq, 4208);
    wait_idle("single_idle");

    // Back-to-back notes.
    push(16'd4208, 8'h80, 16'd2, 1'b0);
    push(16'd3339, 8'h40, 16'd1, 1'b0);
    for (int k = 1; k <= (GAP_ON ? 22 : 14); k++) begin
      if (k > 1) step();
      chk($sformatf("b2b_en_k%0d", k), ch_en,
          GAP_ON ? (((k >= 1 && k <= 8) || (k >= 17 && k <= 20)) ? 1 : 0)
                 : ((k <= 12) ? 1 : 0));
      chk($sformatf("b2b_freq_k%0d", k), ch_freq, (k <= (GAP_ON ? 16 : 8)) ? 4208 : 3339);
    end
    wait_idle("b2b_idle");

    // Zero-duration entry is discarded without output change or idle cycle.
    push(16'd1111, 8'h11, 16'd0, 1'b0);
    push(16'd2222, 8'h22, 16'd1, 1'b0);
    chk("zero_en_k1", ch_en, 0);
    chk("zero_freq_k1", ch_freq, 3339);
    chk("zero_busy_k1", busy, 0);
    step();
    chk("zero_en_k2", ch_en, 1);
    chk("zero_freq_k2", ch_freq, 2222);
    chk("zero_vol_k2", ch_vol, 8'h22);
    for (int k = 3; k <= 6; k++) begin
      step();
      chk($sformatf("zero_en_k%0d", k), ch_en, (k <= 5) ? 1 : 0);
    end
    wait_idle("zero_idle");

    // Pause for 4 edges inside a dur=3 note.
    push(16'd4208, 8'hff, 16'd3, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      pause = (k >= 4 && k <= 7);
      step();
      chk($sformatf("pause_en_k%0d", k), ch_en,
          ((k <= 3) || (k >= 8 && k <= 16)) ? 1 : 0);
    end
    pause = 1'b0;
    wait_idle("pause_idle");

    // Flush with three queued entries and a same-cycle push.
    push(16'd4208, 8'hff, 16'd5, 1'b0);
    push(16'd5000, 8'h01, 16'd1, 1'b0);
    push(16'd5001, 8'h02, 16'd1, 1'b0);
    push(16'd5002, 8'h03, 16'd1, 1'b0);
    chk("flush_pre_level", level, 3);
    chk("flush_pre_en", ch_en, 1);
    flush = 1'b1;
    push(16'd7777, 8'h77, 16'd2, 1'b0);
    flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_en", ch_en, 0);
    chk("flush_busy", busy, 0);
    for (int k = 0; k < 10; k++) step();
    chk("flush_after_en", ch_en, 0);
    chk("flush_after_level", level, 0);
    chk("flush_after_freq", ch_freq, 4208);

    // Fill the FIFO while paused: pushes accepted, no pops, 5th push stalls.
    pause = 1'b1;
    push(16'd100, 8'h01, 16'd1, 1'b0);
    push(16'd101, 8'h02, 16'd1, 1'b0);
    push(16'd102, 8'h03, 16'd1, 1'b0);
    push(16'd103, 8'h04, 16'd1, 1'b0);
    chk("full_level", level, 4);
    chk("full_ready", sif.cmd_ready_o, 0);
    chk("full_busy", busy, 0);
    push(16'd104, 8'h05, 16'd1, 1'b0);
    chk("full_level_5th", level, 4);
    chk("full_ready_5th", sif.cmd_ready_o, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    pause = 1'b0;
    chk("full_flush_level", level, 0);
    chk("full_flush_ready", sif.cmd_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
